// File: rtl/branch_target_buffer_pkg.sv
// Shared definitions for the branch target buffer slice.
//   - Address/instruction widths and the immediate-field width.
//   - Two-bit saturating counter encoding and its update function.
//   - Instruction fields used by the static direct-branch decode.
package branch_target_buffer_pkg;

   localparam int unsigned ADDR  = 16;
   localparam int unsigned WORD  = 32;
   localparam int unsigned W_OPC = 4;
   localparam int unsigned W_IMM = 16;
   localparam int unsigned W_CNT = 2;

   // Opcode class occupies the top W_OPC bits of the instruction word.
   localparam int unsigned         OPC_LSB    = WORD - W_OPC;
   localparam logic [W_OPC-1:0]    OPC_BRANCH = 4'b0100;

   // Register-indirect jumps set both jr bits; immf marks an immediate target.
   localparam int unsigned JR_HI    = 27;
   localparam int unsigned JR_LO    = 26;
   localparam int unsigned IMMF_BIT = 25;

   typedef enum logic [W_CNT-1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } cnt_e;

   // Saturating step towards the resolved outcome.
   function automatic cnt_e cnt_next(input cnt_e c, input logic taken);
      cnt_e n;
      n = c;
      if (taken) begin
         case (c)
            SNT:     n = WNT;
            WNT:     n = WT;
            default: n = ST;
         endcase
      end else begin
         case (c)
            ST:      n = WT;
            WT:      n = WNT;
            default: n = SNT;
         endcase
      end
      return n;
   endfunction

endpackage

// File: rtl/branch_target_buffer_if.sv
// Fetch/decode/execute bus of the branch target buffer.
//   lookup side : stall_i, flush_i, v_i, pc_i, inst_i
//   prediction  : v_o, pc_o, pred_taken_o, pred_addr_o
//   training    : upd_v_i, upd_pc_i, upd_taken_i, upd_target_i
// master drives lookups and training; slave is the predictor.
interface branch_target_buffer_if;
   import branch_target_buffer_pkg::*;

   logic             stall_i;
   logic             flush_i;
   logic             v_i;
   logic [ADDR-1:0]  pc_i;
   logic [WORD-1:0]  inst_i;

   logic             v_o;
   logic [ADDR-1:0]  pc_o;
   logic             pred_taken_o;
   logic [ADDR-1:0]  pred_addr_o;

   logic             upd_v_i;
   logic [ADDR-1:0]  upd_pc_i;
   logic             upd_taken_i;
   logic [ADDR-1:0]  upd_target_i;

   modport master (
      output stall_i, flush_i, v_i, pc_i, inst_i,
      output upd_v_i, upd_pc_i, upd_taken_i, upd_target_i,
      input  v_o, pc_o, pred_taken_o, pred_addr_o
   );

   modport slave (
      input  stall_i, flush_i, v_i, pc_i, inst_i,
      input  upd_v_i, upd_pc_i, upd_taken_i, upd_target_i,
      output v_o, pc_o, pred_taken_o, pred_addr_o
   );

endinterface

// File: rtl/branch_target_buffer_static_decode.sv
// Combinational static decode of direct immediate branches.
//   inst_i     : fetched instruction
//   is_direct  : branch opcode class, not a register jump, immediate target
//   imm_target : zero-extended immediate field
module branch_static_decode
   import branch_target_buffer_pkg::*;
(
   input  logic [WORD-1:0] inst_i,
   output logic            is_direct,
   output logic [ADDR-1:0] imm_target
);

   logic [W_OPC-1:0] opc;
   logic             unused_inst;

   assign opc        = inst_i[WORD-1:OPC_LSB];
   assign is_direct  = (opc == OPC_BRANCH) & ~(inst_i[JR_HI] & inst_i[JR_LO]) & inst_i[IMMF_BIT];
   assign imm_target = ADDR'(inst_i[W_IMM-1:0]);

   // Only a few fields are decoded here; the remaining bits are intentionally ignored.
   assign unused_inst = ^inst_i;

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with static fallback, fetch stage.
//   clk, rst : clock, synchronous active-high reset
//   bus      : branch_target_buffer_if.slave (lookup, registered prediction, training)
// Entry = valid, tag (upper PC bits), target, 2-bit saturating counter.
// Prediction is registered (1-cycle latency); stall holds, flush kills it.
// Optional macro BTB_BYPASS_EN: forward a same-cycle update to the lookup
// of the same index; otherwise the lookup reads pre-update contents.
module branch_target_buffer
   import branch_target_buffer_pkg::*;
#(
   parameter int unsigned ENTRIES         = 16,
   parameter int unsigned IDX_W           = $clog2(ENTRIES),
   parameter int unsigned TAG_W           = ADDR - IDX_W,
   parameter bit          STATIC_FALLBACK = 1'b1
) (
   input  logic                   clk,
   input  logic                   rst,
   branch_target_buffer_if.slave  bus
);

   logic             valid_q [ENTRIES];
   logic [TAG_W-1:0] tag_q   [ENTRIES];
   logic [ADDR-1:0]  tgt_q   [ENTRIES];
   cnt_e             cnt_q   [ENTRIES];

   // ---------------- training ----------------
   logic [IDX_W-1:0] u_idx;
   logic [TAG_W-1:0] u_tag;
   logic             u_hit;
   logic             u_we;
   logic [ADDR-1:0]  u_tgt_n;
   cnt_e             u_cnt_n;

   assign u_idx = bus.upd_pc_i[IDX_W-1:0];
   assign u_tag = bus.upd_pc_i[ADDR-1:IDX_W];
   assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

   always_comb begin
      u_we    = 1'b0;
      u_tgt_n = tgt_q[u_idx];
      u_cnt_n = cnt_q[u_idx];
      if (bus.upd_v_i && !rst) begin
         if (u_hit) begin
            u_we    = 1'b1;
            u_cnt_n = cnt_next(cnt_q[u_idx], bus.upd_taken_i);
            if (bus.upd_taken_i) u_tgt_n = bus.upd_target_i;
         end else if (bus.upd_taken_i) begin
            u_we    = 1'b1;
            u_tgt_n = bus.upd_target_i;
            u_cnt_n = WT;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            valid_q[i] <= 1'b0;
            cnt_q[i]   <= WNT;
         end
      end else if (u_we) begin
         valid_q[u_idx] <= 1'b1;
         cnt_q[u_idx]   <= u_cnt_n;
      end
   end

   // Tag/target need no reset: they are only meaningful behind valid.
   always_ff @(posedge clk) begin
      if (u_we) begin
         tag_q[u_idx] <= u_tag;
         tgt_q[u_idx] <= u_tgt_n;
      end
   end

   // ---------------- lookup ----------------
   logic [IDX_W-1:0] l_idx;
   logic [TAG_W-1:0] l_tag;
   logic             r_valid;
   logic [TAG_W-1:0] r_tag;
   logic [ADDR-1:0]  r_tgt;
   cnt_e             r_cnt;

   assign l_idx = bus.pc_i[IDX_W-1:0];
   assign l_tag = bus.pc_i[ADDR-1:IDX_W];

   always_comb begin
      r_valid = valid_q[l_idx];
      r_tag   = tag_q[l_idx];
      r_tgt   = tgt_q[l_idx];
      r_cnt   = cnt_q[l_idx];
`ifdef BTB_BYPASS_EN
      if (u_we && (u_idx == l_idx)) begin
         r_valid = 1'b1;
         r_tag   = u_tag;
         r_tgt   = u_tgt_n;
         r_cnt   = u_cnt_n;
      end
`endif
   end

   logic            is_direct;
   logic [ADDR-1:0] imm_target;

   branch_static_decode u_static_decode (
      .inst_i     (bus.inst_i),
      .is_direct  (is_direct),
      .imm_target (imm_target)
   );

   logic            hit;
   logic            p_taken;
   logic [ADDR-1:0] p_addr;

   assign hit = r_valid && (r_tag == l_tag);

   always_comb begin
      p_taken = 1'b0;
      p_addr  = bus.pc_i + ADDR'(1);
      if (hit) begin
         if (r_cnt[1]) begin
            p_taken = 1'b1;
            p_addr  = r_tgt;
         end
      end else if (is_direct && STATIC_FALLBACK) begin
         p_taken = 1'b1;
         p_addr  = imm_target;
      end
   end

   // ---------------- output register ----------------
   logic            v_q;
   logic            taken_q;
   logic [ADDR-1:0] pc_q;
   logic [ADDR-1:0] addr_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         v_q     <= 1'b0;
         taken_q <= 1'b0;
         pc_q    <= '0;
         addr_q  <= '0;
      end else if (bus.flush_i) begin
         v_q     <= 1'b0;
         taken_q <= 1'b0;
         pc_q    <= bus.pc_i;
         addr_q  <= p_addr;
      end else if (!bus.stall_i) begin
         v_q     <= bus.v_i;
         taken_q <= bus.v_i & p_taken;
         pc_q    <= bus.pc_i;
         addr_q  <= p_addr;
      end
   end

   assign bus.v_o          = v_q;
   assign bus.pred_taken_o = taken_q;
   assign bus.pc_o         = pc_q;
   assign bus.pred_addr_o  = addr_q;

endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench for branch_target_buffer (ENTRIES=16, STATIC_FALLBACK=1).
// Each driven cycle pushes the expected registered prediction; a monitor pops
// and compares one entry per clock, one time unit after the rising edge.
module tb_branch_target_buffer;
   import branch_target_buffer_pkg::*;

   localparam logic [WORD-1:0] NB = 32'h1000_0000; // not a branch
   localparam logic [WORD-1:0] BR = 32'h4200_0080; // direct branch, imm 0x80
   localparam logic [WORD-1:0] JR = 32'h4E00_0080; // register jump
   localparam logic [WORD-1:0] NI = 32'h4000_0080; // branch without immf

   typedef struct {
      logic            full;
      logic            v;
      logic [ADDR-1:0] pc;
      logic            taken;
      logic [ADDR-1:0] addr;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   branch_target_buffer_if bus ();

   branch_target_buffer #(
      .ENTRIES         (16),
      .STATIC_FALLBACK (1'b1)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic idle();
      bus.stall_i      = 1'b0;
      bus.flush_i      = 1'b0;
      bus.v_i          = 1'b0;
      bus.pc_i         = '0;
      bus.inst_i       = NB;
      bus.upd_v_i      = 1'b0;
      bus.upd_pc_i     = '0;
      bus.upd_taken_i  = 1'b0;
      bus.upd_target_i = '0;
   endtask

   task automatic lk(input logic [ADDR-1:0] pc, input logic [WORD-1:0] inst);
      bus.v_i    = 1'b1;
      bus.pc_i   = pc;
      bus.inst_i = inst;
   endtask

   task automatic up(input logic [ADDR-1:0] pc, input logic taken, input logic [ADDR-1:0] tgt);
      bus.upd_v_i      = 1'b1;
      bus.upd_pc_i     = pc;
      bus.upd_taken_i  = taken;
      bus.upd_target_i = tgt;
   endtask

   // Push the expectation for the inputs currently driven, then advance one cycle.
   task automatic tick(input logic full, input logic ev, input logic [ADDR-1:0] epc,
                       input logic et, input logic [ADDR-1:0] ea);
      exp_t e;
      e.full = full; e.v = ev; e.pc = epc; e.taken = et; e.addr = ea;
      exp_q.push_back(e);
      @(posedge clk);
      #2;
   endtask

   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("v_o", 32'(bus.v_o), 32'(e.v));
            check("pred_taken_o", 32'(bus.pred_taken_o), 32'(e.taken));
            if (e.full || e.v) begin
               check("pc_o", 32'(bus.pc_o), 32'(e.pc));
               check("pred_addr_o", 32'(bus.pred_addr_o), 32'(e.addr));
            end
         end
      end
   end

   initial begin
      idle();
      rst = 1'b1;
      lk('h24, BR);
      tick(1, 0, '0, 0, '0);                               // reset state
      rst = 1'b0;

      idle(); lk('h24, NB); tick(0, 1, 'h24, 0, 'h25);      // miss, sequential
      idle(); lk('h10, BR); tick(0, 1, 'h10, 1, 'h80);      // static direct
      idle(); lk('h10, JR); tick(0, 1, 'h10, 0, 'h11);      // jr not direct
      idle(); lk('h10, NI); tick(0, 1, 'h10, 0, 'h11);      // no immf

      idle(); lk('h24, NB); up('h24, 1, 'h100);             // same-cycle allocate
`ifdef BTB_BYPASS_EN
      tick(0, 1, 'h24, 1, 'h100);
`else
      tick(0, 1, 'h24, 0, 'h25);
`endif
      idle(); lk('h24, NB); tick(0, 1, 'h24, 1, 'h100);     // cnt=10
      idle(); bus.pc_i = 'h24; tick(0, 0, '0, 0, '0);       // v_i=0

      idle(); lk('h24, NB); up('h24, 0, '0);                // 10 -> 01
`ifdef BTB_BYPASS_EN
      tick(0, 1, 'h24, 0, 'h25);
`else
      tick(0, 1, 'h24, 1, 'h100);
`endif
      idle(); lk('h24, NB); up('h24, 0, '0); tick(0, 1, 'h24, 0, 'h25); // 01 -> 00
      idle(); lk('h24, BR); tick(0, 1, 'h24, 0, 'h25);      // hit beats static
      idle(); up('h24, 0, '0);     tick(0, 0, '0, 0, '0);   // floor at 00
      idle(); up('h24, 1, 'h200);  tick(0, 0, '0, 0, '0);   // 01
      idle(); up('h24, 1, 'h300);  tick(0, 0, '0, 0, '0);   // 10
      idle(); lk('h24, NB); tick(0, 1, 'h24, 1, 'h300);
      idle(); up('h24, 1, 'h300);  tick(0, 0, '0, 0, '0);   // 11
      idle(); up('h24, 1, 'h300);  tick(0, 0, '0, 0, '0);   // stays 11
      idle(); up('h24, 0, '0);     tick(0, 0, '0, 0, '0);   // 10
      idle(); up('h24, 0, '0);     tick(0, 0, '0, 0, '0);   // 01
      idle(); lk('h24, NB); tick(0, 1, 'h24, 0, 'h25);

      idle(); lk('h34, NB); tick(0, 1, 'h34, 0, 'h35);      // alias miss
      idle(); lk('h34, BR); tick(0, 1, 'h34, 1, 'h80);      // alias -> static
      idle(); up('h34, 0, '0);     tick(0, 0, '0, 0, '0);   // no allocate
      idle(); lk('h34, NB); tick(0, 1, 'h34, 0, 'h35);
      idle(); up('h34, 1, 'h400);  tick(0, 0, '0, 0, '0);   // replace, cnt=10
      idle(); lk('h34, NB); tick(0, 1, 'h34, 1, 'h400);
      idle(); lk('h24, NB); tick(0, 1, 'h24, 0, 'h25);      // old entry gone
      idle(); up('h34, 0, '0);     tick(0, 0, '0, 0, '0);   // 10 -> 01
      idle(); lk('h34, NB); tick(0, 1, 'h34, 0, 'h35);

      idle(); lk('h10, NB); tick(0, 1, 'h10, 0, 'h11);
      idle(); bus.stall_i = 1'b1; lk('h34, BR); up('h50, 1, 'h500);
      tick(0, 1, 'h10, 0, 'h11);                            // stall 1, update applies
      idle(); bus.stall_i = 1'b1; lk('h34, BR); tick(0, 1, 'h10, 0, 'h11);
      idle(); bus.stall_i = 1'b1; lk('h34, BR); tick(0, 1, 'h10, 0, 'h11);
      idle(); lk('h50, NB); tick(0, 1, 'h50, 1, 'h500);
      idle(); bus.stall_i = 1'b1; bus.flush_i = 1'b1; lk('h50, NB);
      tick(0, 0, '0, 0, '0);                                // flush beats stall
      idle(); lk('h24, NB); tick(0, 1, 'h24, 0, 'h25);

      idle(); rst = 1'b1; lk('h24, BR); up('h24, 1, 'h700);
      tick(1, 0, '0, 0, '0);                                // reset mid-stream
      rst = 1'b0;
      idle(); lk('h50, NB); tick(0, 1, 'h50, 0, 'h51);      // table cleared
      idle(); lk('h24, NB); tick(0, 1, 'h24, 0, 'h25);      // update dropped
      idle();

      for (int i = 0; i < 8 && exp_q.size() != 0; i++) @(posedge clk);
      #2;
      check("drain", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
